// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, Rcon table, key-schedule FSM states,
// and GF(2^8) helpers (xtime, InvMixColumns).
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OUT  = 3'd1,
    ST_XOR  = 3'd2,
    ST_SUB  = 3'd3,
    ST_COMB = 3'd4
  } state_t;

  // Round constant for rounds 1..10; zero elsewhere.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; byte 0 is the MSB of the word.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
    return {inv_mix_column(st[127:96]), inv_mix_column(st[95:64]),
            inv_mix_column(st[63:32]),  inv_mix_column(st[31:0])};
  endfunction

endpackage

// File: rtl/inv_key_schedule_sbox.sv
// 32-bit AES forward S-box (four byte lanes), purely combinational.
// Each byte is computed as the GF(2^8) inverse (x^254) followed by the
// FIPS-197 affine transform, so no lookup ROM is needed.
module inv_key_schedule_sbox
  import aes_pkg::*;
(
  input  logic [31:0] Sbox_i,
  output logic [31:0] Sbox_o
);

  localparam logic [7:0] INV_EXP = 8'hfe;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (INV_EXP[i]) inv = gf_mul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Substitute every byte lane independently.
  always_comb begin
    Sbox_o = 32'h0;
    for (int i = 0; i < 4; i++) begin
      Sbox_o[8*i +: 8] = sbox_byte(Sbox_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: starting from the last round key, emits
// round keys NR down to 0 over a valid/ready handshake, one new key every
// four cycles (XOR, SUB, COMB, OUT).
// Optional macro INV_KEY_SCHEDULE_EQINV_EN: rounds 1..NR-1 are presented as
// InvMixColumns(key) for the equivalent inverse cipher; the stored key is
// never transformed.
//
// state | meaning
// IDLE  | waiting for start
// OUT   | round key presented, waiting for rk_ready
// XOR   | derive words 1..3 of the previous round key
// SUB   | SubWord(RotWord(p3)) through the shared S-box
// COMB  | derive word 0, load key, decrement round
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key_i,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  state_t state, state_nxt;

  logic [127:0] key;
  logic [3:0]   round;
  logic [31:0]  p1, p2, p3, sub_w;
  logic [31:0]  sbox_in, sbox_out;
  logic         done_q;
  logic         xfer;

  assign sbox_in = {p3[23:0], p3[31:24]};

  inv_key_schedule_sbox u_sbox (
    .Sbox_i (sbox_in),
    .Sbox_o (sbox_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    rk_valid  = 1'b0;
    busy      = 1'b1;
    xfer      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        rk_valid = 1'b1;
        xfer     = rk_ready;
        if (rk_ready) state_nxt = (round == 4'd0) ? ST_IDLE : ST_XOR;
      end
      ST_XOR:  state_nxt = ST_SUB;
      ST_SUB:  state_nxt = ST_COMB;
      ST_COMB: state_nxt = ST_OUT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Key datapath: one step of the inverse expansion per state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key    <= 128'h0;
      round  <= 4'd0;
      p1     <= 32'h0;
      p2     <= 32'h0;
      p3     <= 32'h0;
      sub_w  <= 32'h0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer && (round == 4'd0);
      case (state)
        ST_IDLE: begin
          if (start) begin
            key   <= last_key_i;
            round <= 4'(NR);
          end
        end
        ST_XOR: begin
          p3 <= key[31:0]  ^ key[63:32];
          p2 <= key[63:32] ^ key[95:64];
          p1 <= key[95:64] ^ key[127:96];
        end
        ST_SUB: sub_w <= sbox_out;
        ST_COMB: begin
          key <= {key[127:96] ^ sub_w ^ {rcon(round), 24'h0}, p1, p2, p3};
          if (round != 4'd0) round <= round - 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef INV_KEY_SCHEDULE_EQINV_EN
  assign rk_o = ((round != 4'd0) && (round != 4'(NR))) ? inv_mix_columns(key) : key;
`else
  assign rk_o = key;
`endif

  assign rk_round = round;
  assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using the FIPS-197 AES-128 key.
module tb_inv_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key_i;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_o;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  inv_key_schedule #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .last_key_i (last_key_i),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_o       (rk_o),
    .rk_round   (rk_round),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] fips_rk(input int r);
    logic [127:0] k;
    case (r)
      0:  k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      1:  k = 128'ha0fafe1788542cb123a339392a6c7605;
      2:  k = 128'hf2c295f27a96b9435935807a7359f67f;
      3:  k = 128'h3d80477d4716fe3e1e237e446d7a883b;
      4:  k = 128'hef44a541a8525b7fb671253bdb0bad00;
      5:  k = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      6:  k = 128'h6d88a37a110b3efddbf98641ca0093fd;
      7:  k = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      8:  k = 128'head27321b58dbad2312bf5607f8d292f;
      9:  k = 128'hac7766f319fadc2128d12941575c006e;
      10: k = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      default: k = 128'h0;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [127:0] tb_imc(input logic [127:0] s);
    logic [127:0] o;
    logic [31:0]  coef;
    logic [7:0]   acc;
    coef = 32'h0e0b0d09;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ tb_gmul(coef[31-8*((k-row+4)%4) -: 8], s[127-32*c-8*k -: 8]);
        end
        o[127-32*c-8*row -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] expected_rk(input int r);
`ifdef INV_KEY_SCHEDULE_EQINV_EN
    if (r >= 1 && r <= 9) return tb_imc(fips_rk(r));
`endif
    return fips_rk(r);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [127:0] key);
    start      = 1'b1;
    last_key_i = key;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", rk_valid, 1);
    chk("first_done_low", done, 0);
  endtask

  // Consume keys 10 down to last_r; optionally stall one round and poke start.
  task automatic take_keys(input int last_r, input int stall_r, input bit poke);
    int gap;
    gap = 0;
    for (int r = 10; r >= last_r; r--) begin
      if (r != 10) begin
        while (!rk_valid && gap < 20) begin
          @(negedge clk);
          gap++;
        end
        chk($sformatf("gap_r%0d", r), gap, 4);
      end
      chk($sformatf("valid_r%0d", r), rk_valid, 1);
      chk($sformatf("round_r%0d", r), rk_round, r);
      chk($sformatf("key_r%0d", r), rk_o, expected_rk(r));
      chk($sformatf("busy_r%0d", r), busy, 1);
      if (r == stall_r) begin
        rk_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk($sformatf("stall%0d_valid", s), rk_valid, 1);
          chk($sformatf("stall%0d_round", s), rk_round, r);
          chk($sformatf("stall%0d_key", s), rk_o, expected_rk(r));
        end
        rk_ready = 1'b1;
      end
      if (poke && r == 8) begin
        start      = 1'b1;
        last_key_i = 128'h00112233445566778899aabbccddeeff;
      end
      @(negedge clk);
      gap = 1;
      if (poke && r == 8) begin
        chk("poke_busy", busy, 1);
        @(negedge clk);
        gap = 2;
        start      = 1'b0;
        last_key_i = K10;
      end
      if (r == 0) begin
        chk("done_pulse", done, 1);
        chk("done_idle", busy, 0);
      end else begin
        chk($sformatf("done_low_r%0d", r), done, 0);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    rk_ready   = 1'b1;
    last_key_i = 128'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", rk_valid, 0);
    chk("rst_key", rk_o, 0);
    chk("rst_round", rk_round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", rk_valid, 0);
    chk("idle_busy", busy, 0);

    // Plain sequence with rk_ready held high.
    do_start(K10);
    take_keys(0, -1, 1'b0);

    // Start coincident with done; stall in round 7; start poked in OUT/XOR.
    do_start(K10);
    take_keys(0, 7, 1'b1);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("end_busy", busy, 0);
    chk("end_valid", rk_valid, 0);

    // Reset while SUB is computing the round-5 key.
    do_start(K10);
    take_keys(6, -1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", rk_valid, 0);
    chk("abort_key", rk_o, 0);
    chk("abort_round", rk_round, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_abort_valid", rk_valid, 0);
    chk("post_abort_busy", busy, 0);
    do_start(K10);
    take_keys(0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only value 10 supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  begin inverse expansion; sampled only in IDLE.
REQ-005 SHALL have port last_key_i  input  128  round-NR key, FIPS-197 order, w0 = bits[127:96], byte 0 = MSB of word.
REQ-006 SHALL have port rk_valid  output  1  rk_o/rk_round hold a valid round key.
REQ-007 SHALL have port rk_ready  input  1  consumer accepts round key; transfer when rk_valid && rk_ready.
REQ-008 SHALL have port rk_o  output  128  current round key, same word/byte order as last_key_i.
REQ-009 SHALL have port rk_round  output  4  round index of rk_o, NR down to 0.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse after round-0 key transfer.

Function
REQ-012 SHALL implement FSM states IDLE, OUT, XOR, SUB, COMB.
REQ-013 IDLE: start=1 captures last_key_i into key register, sets round=NR, next state OUT.
REQ-014 OUT: rk_valid=1; rk_o, rk_round SHALL stay stable until transfer.
REQ-015 OUT transfer with round==0: next state IDLE, done=1 for exactly that next cycle.
REQ-016 OUT transfer with round>0: next state XOR.
REQ-017 XOR: with current key words w0..w3, register p3=w3^w2, p2=w2^w1, p1=w1^w0; next SUB.
REQ-018 SUB: register SubWord(RotWord(p3)), RotWord = left byte rotate; next COMB.
REQ-019 COMB: p0 = w0 ^ sub ^ {Rcon[round],24'h0}; key := {p0,p1,p2,p3}; round := round-1; next OUT.
REQ-020 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-021 First rk_valid SHALL assert 1 cycle after start accepted; each subsequent rk_valid SHALL assert exactly 4 cycles after preceding transfer.
REQ-022 start outside IDLE, and rk_ready while rk_valid=0, SHALL be ignored.
REQ-023 start in same cycle as done pulse (state IDLE) SHALL be accepted normally.
REQ-024 All XOR arithmetic is GF(2) bytewise; round counter 4 bits, never wraps below 0.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, rk_valid=0, rk_o=0, rk_round=0, busy=0, done=0, internal registers 0.
REQ-026 Reset mid-operation SHALL abort the sequence; no further round keys emitted until a new start.

Configuration
REQ-027 Macro INV_KEY_SCHEDULE_EQINV_EN defined: rk_o for rounds 1..NR-1 SHALL be InvMixColumns(key) (equivalent inverse cipher); rounds 0 and NR unmodified; internal key register always untransformed.
REQ-028 Macro undefined: rk_o SHALL equal the raw round key for all rounds; no InvMixColumns logic present.

Structure
REQ-029 Shared package aes_pkg SHALL hold NR constant, Rcon table, FSM state typedef, and GF(2^8) xtime/InvMixColumns functions.
REQ-030 SHALL instantiate the existing 32-bit Sbox sub-module (Sbox_i/Sbox_o) once for SubWord; no other sub-modules.

Verification
REQ-031 start with last_key_i=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> round 10 key equals input, round 9 = ac7766f319fadc2128d12941575c006e, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, done pulses once.
REQ-032 Same stimulus, rk_ready held 0 for 5 cycles in round 7 -> rk_o/rk_round stable throughout, sequence resumes unchanged.
REQ-033 rst_n=0 during SUB of round 5 -> next cycle all outputs 0, busy=0; fresh start yields full correct 11-key sequence.
REQ-034 start pulsed during OUT and XOR -> ignored, sequence and timing unchanged; start coincident with done -> new sequence begins 1 cycle later.
REQ-035 With INV_KEY_SCHEDULE_EQINV_EN defined, FIPS-197 key -> rounds 1..9 equal InvMixColumns of REQ-031 keys, rounds 0/10 raw.
REQ-036 Cycle check: transfer-to-next-rk_valid gap exactly 4 cycles for all 10 transitions.
